uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: the receive-side counterpart of `uart_tx` in the UART block.
- Oversamples the asynchronous serial line `rx_sig` with the system clock and deserialises 8N1-style frames: 1 start bit, `DATA_WIDTH` data bits sent LSB first, 1 stop bit, no parity.
- Presents each good byte to the host through a one-entry output register with a valid/ready handshake.
- Reports framing errors and overruns as single-cycle pulses.

## Interface
Parameters:
- `DATA_WIDTH`, 8, data bits per frame.
- `BAUD_RATE`, 115200, line rate in bit/s.
- `CLK_FREQ`, 100_000_000, `clk` frequency in Hz.
- Derived constants:
  - `PULSE_WIDTH = CLK_FREQ / BAUD_RATE` (integer division, 868 at defaults).
  - `HALF_PULSE = PULSE_WIDTH / 2` (434).

Ports:
- `clk`  in  1  system clock; one clock domain, everything on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `rx_sig`  in  1  asynchronous serial line, idle high.
- `data_to_host`  out  `DATA_WIDTH`  received byte; stable while `valid_to_host`=1.
- `valid_to_host`  out  1  output register holds an unread byte.
- `ready_from_host`  in  1  host accepts the byte this cycle.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because the output register is full.

## Operation
Input synchroniser:
- Two-flop synchroniser on `rx_sig` produces `rx_s`.
- A third flop holds `rx_prev`, the previous value of `rx_s`.
- All three flops reset to 0. A line that is already low at reset release therefore cannot start a frame: the line must be seen high first.

Start detection:
- A start edge is `rx_prev`=1 and `rx_s`=0, and it is honoured only in IDLE.

Bit counter `cnt`:
- Width is `$clog2(PULSE_WIDTH)`.
- Cleared on every state transition and on every sample.

Bit index `idx`:
- Width is `$clog2(DATA_WIDTH)`.
- Counts data bits received.

FSM states:
- IDLE: `cnt`=0. On a start edge, go to START.
- START: increment `cnt`. When `cnt`==`HALF_PULSE`-1, sample `rx_s`.
  - Sample is 0: go to DATA with `idx`=0.
  - Sample is 1: the edge was a glitch; go to IDLE with no output activity.
- DATA: increment `cnt`. When `cnt`==`PULSE_WIDTH`-1, sample `rx_s` and shift it into the MSB of the shift register (right shift, so the first bit received ends up at bit 0).
  - If `idx`==`DATA_WIDTH`-1, go to STOP.
  - Otherwise increment `idx`.
- STOP: increment `cnt`. When `cnt`==`PULSE_WIDTH`-1, sample `rx_s` and go to IDLE in all cases.
  - Sample is 1: the frame is good.
  - Sample is 0: pulse `frame_err` and discard the byte.

After the stop-bit decision the FSM returns to IDLE at mid-stop-bit, so a start bit that follows immediately is caught. A break (line held low) produces one `frame_err` and then no further frames until the line has returned high and falls again.

Output register (good frame only):
- Register empty, or `valid_to_host`=1 with `ready_from_host`=1 in the same cycle: load `data_to_host` and set `valid_to_host`=1.
- Register full and not being read: keep the old byte, drop the new one, pulse `overrun`.
- Otherwise, `valid_to_host`=1 with `ready_from_host`=1 clears `valid_to_host`.
- `ready_from_host` has no effect while `valid_to_host`=0.

## Timing
Reset:
- With `rst`=1 on a clock edge: FSM goes to IDLE; `cnt`, `idx` and the shift register go to 0.
- Outputs after reset: `data_to_host`=0, `valid_to_host`=0, `frame_err`=0, `overrun`=0.
- Reset in the middle of a frame abandons the frame and clears any unread byte. The rest of the current frame cannot restart reception unless a new falling edge appears.

Sample points, where E is the first cycle with `rx_s`=0 and `rx_prev`=1 (two to three cycles after `rx_sig` falls):
- Start bit sampled at E+`HALF_PULSE`.
- Data bit i sampled at E+`HALF_PULSE`+(i+1)·`PULSE_WIDTH`.
- Stop bit sampled at E+`HALF_PULSE`+(`DATA_WIDTH`+1)·`PULSE_WIDTH`.

Output timing:
- `valid_to_host`, `frame_err` and `overrun` are registered and become visible in the cycle after the stop-bit sample.
- Each pulse is exactly one cycle wide.
- Sustained throughput is one byte per frame time. A host with `ready_from_host` tied to 1 never sees `overrun`.

## Test plan
- Idle line high for 50·`PULSE_WIDTH`, `ready_from_host`=1 -> `valid_to_host`, `frame_err` and `overrun` all stay 0.
- Frame 0xA5 with a good stop bit, `ready_from_host`=1 -> `data_to_host`=0xA5 and `valid_to_host` high for one cycle, both at E+434+9·868+1.
- Frames 0xC4, 0xB5, 0x9A sent back-to-back (no idle gap), `ready_from_host`=0 until the end, then 1 -> 0xC4 held throughout; one `overrun` pulse per dropped byte (two in total); 0xC4 is read once and `valid_to_host` drops.
- Frame 0x3C with the stop bit forced low, then the line held low for 3 frame times, then high -> exactly one `frame_err`; `valid_to_host` stays 0; a following 0x81 frame is received correctly.
- `rx_sig` low for 100 cycles (less than `HALF_PULSE`), then high -> no output activity; a following 0x55 frame is received correctly.
- `rst` pulsed for 1 cycle in the middle of data bit 4 of a 0xF0 frame, then a 0x0F frame -> no byte appears for 0xF0; 0x0F is received correctly. Loopback from `uart_tx` at the same parameters returns every byte it transmits.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: oversamples an asynchronous line, deserialises start/data/stop
// frames and hands each good byte to the host through a one-entry valid/ready register.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_sig,
    output logic [DATA_WIDTH-1:0] data_to_host,
    output logic                  valid_to_host,
    input  logic                  ready_from_host,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE  = PULSE_WIDTH / 2;
    localparam int CNT_W       = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PULSE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic                  r_sync;
    logic                  r_rx_s;
    logic                  r_rx_prev;
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_frame_err;
    logic                  r_overrun;

    logic w_start_edge;
    logic w_bit_tick;
    logic w_stop_good;
    logic w_read;

    assign w_start_edge = r_rx_prev & ~r_rx_s;
    assign w_bit_tick   = (r_cnt == CNT_LAST);
    assign w_stop_good  = (r_state == S_STOP) && w_bit_tick && r_rx_s;
    assign w_read       = r_valid & ready_from_host;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= 1'b0;
            r_rx_s      <= 1'b0;
            r_rx_prev   <= 1'b0;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // Flops reset low so a line already low at reset release cannot look like an edge.
            r_sync      <= rx_sig;
            r_rx_s      <= r_sync;
            r_rx_prev   <= r_rx_s;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_start_edge) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
                        if (r_idx == IDX_LAST) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start edge is still caught.
                    if (w_bit_tick) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase

            if (w_stop_good) begin
                if (!r_valid || ready_from_host) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_read) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_to_host  = r_data;
    assign valid_to_host = r_valid;
    assign frame_err     = r_frame_err;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: idle, good frames, overrun,
// framing error/break, glitch rejection and mid-frame reset.
module tb_uart_rx;

    localparam int PW = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_sig = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;

    int n_vec = 0;
    int n_err = 0;

    uart_rx #(
        .DATA_WIDTH(8),
        .BAUD_RATE (62_500),
        .CLK_FREQ  (1_000_000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_sig         (rx_sig),
        .data_to_host   (data),
        .valid_to_host  (valid),
        .ready_from_host(ready),
        .frame_err      (ferr),
        .overrun        (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got[$];
    int         rise_cyc[$];
    int         valid_cycles = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic       valid_d = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                valid_cycles++;
                if (!valid_d) rise_cyc.push_back(cyc);
                if (ready) begin
                    got.push_back(data);
                    $display("[%0d] host read byte 0x%02h", cyc, data);
                end
            end
            if (ferr) begin
                fe_cnt++;
                $display("[%0d] frame_err pulse", cyc);
            end
            if (ovr) begin
                ov_cnt++;
                $display("[%0d] overrun pulse", cyc);
            end
        end
        valid_d = valid & ~rst;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_sig = b;
        tick(PW);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_sig = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", data); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_vec++; if (ferr !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
        n_vec++; if (ovr !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
    endtask

    task automatic test_idle;
        int vb, fb, ob;
        vb = valid_cycles; fb = fe_cnt; ob = ov_cnt;
        rx_sig = 1'b1;
        ready = 1'b1;
        tick(50 * PW);
        n_vec++; if (valid_cycles - vb !== 0) begin n_err++; $display("FAIL idle_valid: got %0d cycles expected 0", valid_cycles - vb); end
        n_vec++; if (fe_cnt - fb !== 0) begin n_err++; $display("FAIL idle_ferr: got %0d expected 0", fe_cnt - fb); end
        n_vec++; if (ov_cnt - ob !== 0) begin n_err++; $display("FAIL idle_ovr: got %0d expected 0", ov_cnt - ob); end
    endtask

    task automatic test_good_frame;
        int gb, rb, vb, fall;
        gb = got.size(); rb = rise_cyc.size(); vb = valid_cycles;
        ready = 1'b1;
        fall = cyc;
        send_frame(8'hA5, 1'b1);
        tick(2 * PW);
        n_vec++; if (got.size() !== gb + 1) begin n_err++; $display("FAIL a5_count: got %0d bytes expected 1", got.size() - gb); end
        n_vec++; if (got.size() <= gb || got[gb] !== 8'hA5) begin n_err++; $display("FAIL a5_data: got %h expected a5", (got.size() > gb) ? got[gb] : 8'hxx); end
        // Fall + 2 sync flops + 1 edge cycle + HALF(8) + 9*PW(144) = 155.
        n_vec++; if (rise_cyc.size() <= rb || rise_cyc[rb] - fall !== 155) begin n_err++; $display("FAIL a5_latency: got %0d expected 155", (rise_cyc.size() > rb) ? rise_cyc[rb] - fall : -1); end
        n_vec++; if (valid_cycles - vb !== 1) begin n_err++; $display("FAIL a5_valid_width: got %0d expected 1", valid_cycles - vb); end
    endtask

    task automatic test_back_to_back;
        int gb, ob, fb;
        gb = got.size(); ob = ov_cnt; fb = fe_cnt;
        ready = 1'b0;
        send_frame(8'hC4, 1'b1);
        send_frame(8'hB5, 1'b1);
        send_frame(8'h9A, 1'b1);
        tick(PW);
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid_held: got %b expected 1", valid); end
        n_vec++; if (data !== 8'hC4) begin n_err++; $display("FAIL b2b_data_held: got %h expected c4", data); end
        n_vec++; if (ov_cnt - ob !== 2) begin n_err++; $display("FAIL b2b_overruns: got %0d expected 2", ov_cnt - ob); end
        n_vec++; if (fe_cnt - fb !== 0) begin n_err++; $display("FAIL b2b_ferr: got %0d expected 0", fe_cnt - fb); end
        ready = 1'b1;
        tick(1);
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop: got %b expected 0", valid); end
        tick(PW);
        n_vec++; if (got.size() !== gb + 1 || got[gb] !== 8'hC4) begin n_err++; $display("FAIL b2b_read_once: got %0d bytes expected 1 (c4)", got.size() - gb); end
    endtask

    task automatic test_frame_error;
        int gb, fb, vb;
        gb = got.size(); fb = fe_cnt; vb = valid_cycles;
        ready = 1'b1;
        send_frame(8'h3C, 1'b0);
        rx_sig = 1'b0;
        tick(3 * 10 * PW);
        rx_sig = 1'b1;
        tick(2 * PW);
        n_vec++; if (fe_cnt - fb !== 1) begin n_err++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - fb); end
        n_vec++; if (valid_cycles - vb !== 0) begin n_err++; $display("FAIL ferr_no_valid: got %0d cycles expected 0", valid_cycles - vb); end
        send_frame(8'h81, 1'b1);
        tick(2 * PW);
        n_vec++; if (got.size() !== gb + 1 || got[gb] !== 8'h81) begin n_err++; $display("FAIL ferr_next_frame: got %0d bytes expected 1 (81)", got.size() - gb); end
        n_vec++; if (fe_cnt - fb !== 1) begin n_err++; $display("FAIL ferr_after_next: got %0d expected 1", fe_cnt - fb); end
    endtask

    task automatic test_glitch;
        int gb, fb, ob, vb;
        gb = got.size(); fb = fe_cnt; ob = ov_cnt; vb = valid_cycles;
        rx_sig = 1'b0;
        tick(4);
        rx_sig = 1'b1;
        tick(2 * PW);
        n_vec++; if (valid_cycles - vb !== 0) begin n_err++; $display("FAIL glitch_valid: got %0d cycles expected 0", valid_cycles - vb); end
        n_vec++; if (fe_cnt - fb !== 0 || ov_cnt - ob !== 0) begin n_err++; $display("FAIL glitch_pulses: got ferr %0d ovr %0d expected 0 0", fe_cnt - fb, ov_cnt - ob); end
        send_frame(8'h55, 1'b1);
        tick(2 * PW);
        n_vec++; if (got.size() !== gb + 1 || got[gb] !== 8'h55) begin n_err++; $display("FAIL glitch_next_frame: got %0d bytes expected 1 (55)", got.size() - gb); end
    endtask

    task automatic test_reset_mid_frame;
        int gb, fb;
        gb = got.size(); fb = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx_sig = 1'b1;
        tick(PW / 2);
        rst = 1'b1;
        tick(1);
        n_vec++; if (data !== 8'h00 || valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_clear: got data %h valid %b expected 00 0", data, valid); end
        rst = 1'b0;
        tick(PW / 2 - 1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        tick(PW);
        n_vec++; if (got.size() !== gb || fe_cnt - fb !== 0) begin n_err++; $display("FAIL rst_mid_abandon: got %0d bytes %0d ferr expected 0 0", got.size() - gb, fe_cnt - fb); end
        send_frame(8'h0F, 1'b1);
        tick(2 * PW);
        n_vec++; if (got.size() !== gb + 1 || got[gb] !== 8'h0F) begin n_err++; $display("FAIL rst_mid_next_frame: got %0d bytes expected 1 (0f)", got.size() - gb); end
    endtask

    initial begin
        test_reset;
        test_idle;
        test_good_frame;
        test_back_to_back;
        test_frame_error;
        test_glitch;
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
